// File: rtl/alu_op_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer_if
// Description : Bundle of the request/response handshake and the ALU-side
//               operand/select/result bus used by alu_op_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_op_sequencer_if #(
    parameter int WIDTH = 32
);
    // Request side
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // ALU side
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;

    // Response side
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_by_zero;
    logic             timeout;

    // Driver / environment view: issues requests and supplies the ALU result
    modport master (
        output start, op, a, b, alu_result,
        input  alu_sel, alu_a, alu_b, busy, done, result, div_by_zero, timeout
    );

    // Sequencer view
    modport slave (
        input  start, op, a, b, alu_result,
        output alu_sel, alu_a, alu_b, busy, done, result, div_by_zero, timeout
    );
endinterface
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : alu_op_sequencer
// Description : Drives a shared 8-function combinational ALU to execute one
//               operation per transaction. Single-function ops use one ALU
//               cycle; mod is built from alternating slt/sub cycles
//               (repeated subtraction) with an iteration limit.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer #(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 16,
    parameter int MAX_ITER = 65535
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    alu_op_sequencer_if.slave    bus
);

    localparam logic [2:0]       c_op_and  = 3'b000;
    localparam logic [2:0]       c_op_slt  = 3'b100;
    localparam logic [2:0]       c_op_sub  = 3'b110;
    localparam logic [2:0]       c_op_mod  = 3'b111;
    localparam logic [CNT_W-1:0] c_max_iter = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_CMP  = 3'd2,
        S_SUB  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_iter;
    logic [WIDTH-1:0] r_result;
    logic             r_div_by_zero;
    logic             r_timeout;

    logic             w_rem_lt_b;
    logic             w_iter_limit;

    // In CMP the ALU performs slt(rem, b); bit 0 says the remainder is final
    assign w_rem_lt_b   = bus.alu_result[0];
    assign w_iter_limit = (r_iter == c_max_iter);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and combinational ALU/status outputs
    always_comb begin
        w_state_next = r_state;
        bus.alu_sel  = c_op_and;
        bus.alu_a    = '0;
        bus.alu_b    = '0;
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op != c_op_mod) begin
                        w_state_next = S_EXEC;
                    end else if (bus.b == '0) begin
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_CMP;
                    end
                end
            end
            S_EXEC: begin
                bus.busy     = 1'b1;
                bus.alu_sel  = r_op;
                bus.alu_a    = r_a;
                bus.alu_b    = r_b;
                w_state_next = S_DONE;
            end
            S_CMP: begin
                bus.busy    = 1'b1;
                bus.alu_sel = c_op_slt;
                bus.alu_a   = r_rem;
                bus.alu_b   = r_b;
                if (w_rem_lt_b || w_iter_limit) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_SUB;
                end
            end
            S_SUB: begin
                bus.busy     = 1'b1;
                bus.alu_sel  = c_op_sub;
                bus.alu_a    = r_rem;
                bus.alu_b    = r_b;
                w_state_next = S_CMP;
            end
            S_DONE: begin
                bus.done     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, remainder/iteration tracking and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op          <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_rem         <= '0;
            r_iter        <= '0;
            r_result      <= '0;
            r_div_by_zero <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op          <= bus.op;
                        r_a           <= bus.a;
                        r_b           <= bus.b;
                        r_result      <= '0;
                        r_div_by_zero <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_iter        <= '0;
                        if (bus.op == c_op_mod) begin
                            if (bus.b == '0) begin
                                r_div_by_zero <= 1'b1;
                            end else begin
                                r_rem <= bus.a;
                            end
                        end
                    end
                end
                S_EXEC: begin
                    r_result <= bus.alu_result;
                end
                S_CMP: begin
                    // The slt answer takes priority: a remainder that is
                    // already below b on the last allowed pass is a clean result
                    if (w_rem_lt_b) begin
                        r_result <= r_rem;
                    end else if (w_iter_limit) begin
                        r_result  <= r_rem;
                        r_timeout <= 1'b1;
                    end
                end
                S_SUB: begin
                    r_rem  <= bus.alu_result;
                    r_iter <= r_iter + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.result      = r_result;
    assign bus.div_by_zero = r_div_by_zero;
    assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_op_sequencer
// Description : Self-checking bench for alu_op_sequencer. Two instances: one
//               with default limits, one with MAX_ITER=4 for the abort path.
//               A behavioural ALU closes the loop; expected results and
//               latencies come from an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    localparam int WIDTH      = 32;
    localparam int MAX_ITER_0 = 65535;
    localparam int MAX_ITER_1 = 4;

    logic clk;
    logic rst_n0;
    logic rst_n1;

    int n_checks = 0;
    int n_errors = 0;

    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus0 ();
    alu_op_sequencer_if #(.WIDTH(WIDTH)) bus1 ();

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(16), .MAX_ITER(MAX_ITER_0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (bus0)
    );

    alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(3), .MAX_ITER(MAX_ITER_1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-function ALU
    function automatic logic [31:0] alu_fn(logic [2:0] s, logic [31:0] x, logic [31:0] y);
        case (s)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x ^ y;
            3'b011:  return ~(x | y);
            3'b100:  return {31'b0, ($signed(x) < $signed(y))};
            3'b101:  return x + y;
            3'b110:  return x - y;
            default: return 32'h0;
        endcase
    endfunction

    always_comb bus0.alu_result = alu_fn(bus0.alu_sel, bus0.alu_a, bus0.alu_b);
    always_comb bus1.alu_result = alu_fn(bus1.alu_sel, bus1.alu_a, bus1.alu_b);

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] aa;
        logic [31:0] bb;
        logic        busy;
        logic        done;
        logic [31:0] res;
        logic        dbz;
        logic        to;
    } snap_t;

    function automatic snap_t snap(int inst);
        snap_t s;
        if (inst == 0) begin
            s = '{bus0.alu_sel, bus0.alu_a, bus0.alu_b, bus0.busy, bus0.done,
                  bus0.result, bus0.div_by_zero, bus0.timeout};
        end else begin
            s = '{bus1.alu_sel, bus1.alu_a, bus1.alu_b, bus1.busy, bus1.done,
                  bus1.result, bus1.div_by_zero, bus1.timeout};
        end
        return s;
    endfunction

    task automatic drive(int inst, logic s, logic [2:0] o, logic [31:0] x, logic [31:0] y);
        if (inst == 0) begin
            bus0.start = s; bus0.op = o; bus0.a = x; bus0.b = y;
        end else begin
            bus1.start = s; bus1.op = o; bus1.a = x; bus1.b = y;
        end
    endtask

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: result, flags and done latency from plain arithmetic
    task automatic ref_model(logic [2:0] o, logic [31:0] x, logic [31:0] y, int max_iter,
                             output logic [31:0] res, output logic dbz,
                             output logic to, output int lat);
        longint q;
        dbz = 1'b0;
        to  = 1'b0;
        if (o != 3'b111) begin
            res = alu_fn(o, x, y);
            lat = 2;
        end else if (y == 0) begin
            res = 32'h0;
            dbz = 1'b1;
            lat = 1;
        end else begin
            q = longint'(x) / longint'(y);
            if (q > longint'(max_iter)) begin
                res = 32'(longint'(x) - longint'(max_iter) * longint'(y));
                to  = 1'b1;
                lat = 2 * max_iter + 2;
            end else begin
                res = x % y;
                lat = 2 * int'(q) + 2;
            end
        end
    endtask

    // One full transaction: start, watch the busy window while pulsing
    // ignored starts with junk operands, then check completion and hold.
    task automatic run_txn(int inst, logic [2:0] o, logic [31:0] x, logic [31:0] y, string tag);
        logic [31:0] e_res;
        logic        e_dbz;
        logic        e_to;
        int          e_lat;
        int          n;
        logic        busy_ok;
        logic        sel_ok;
        snap_t       s;

        ref_model(o, x, y, (inst == 0) ? MAX_ITER_0 : MAX_ITER_1, e_res, e_dbz, e_to, e_lat);

        @(negedge clk);
        drive(inst, 1'b1, o, x, y);
        @(posedge clk);
        n = 1;
        #1;
        drive(inst, 1'b0, 3'($urandom), $urandom, $urandom);
        s = snap(inst);

        if (e_lat > 1) begin
            check({tag, " first sel"},    64'(s.sel), (o == 3'b111) ? 64'd4 : 64'(o));
            check({tag, " first alu_a"},  64'(s.aa), 64'(x));
            check({tag, " first alu_b"},  64'(s.bb), 64'(y));
            check({tag, " result clear"}, 64'(s.res), 64'd0);
        end

        busy_ok = 1'b1;
        sel_ok  = 1'b1;
        while (!s.done && n < e_lat + 20) begin
            if (!s.busy) busy_ok = 1'b0;
            if (o == 3'b111 && s.sel != ((n % 2 == 1) ? 3'b100 : 3'b110)) sel_ok = 1'b0;
            drive(inst, 1'($urandom), 3'($urandom), $urandom, $urandom);
            @(posedge clk);
            n++;
            #1;
            s = snap(inst);
        end
        drive(inst, 1'b0, 3'b000, 32'h0, 32'h0);

        check({tag, " done"},    64'(s.done), 64'd1);
        check({tag, " latency"}, 64'(n), 64'(e_lat));
        check({tag, " result"},  64'(s.res), 64'(e_res));
        check({tag, " dbz"},     64'(s.dbz), 64'(e_dbz));
        check({tag, " timeout"}, 64'(s.to), 64'(e_to));
        check({tag, " busy@done"}, 64'(s.busy), 64'd0);
        check({tag, " busy window"}, 64'(busy_ok), 64'd1);
        if (o == 3'b111) check({tag, " slt/sub order"}, 64'(sel_ok), 64'd1);

        @(posedge clk);
        #1;
        s = snap(inst);
        check({tag, " done pulse"},  64'(s.done), 64'd0);
        check({tag, " idle busy"},   64'(s.busy), 64'd0);
        check({tag, " result hold"}, 64'(s.res), 64'(e_res));
        check({tag, " idle sel"},    64'(s.sel), 64'd0);
    endtask

    task automatic check_zero(int inst, string tag);
        snap_t s;
        s = snap(inst);
        check({tag, " alu_sel"}, 64'(s.sel),  64'd0);
        check({tag, " alu_a"},   64'(s.aa),   64'd0);
        check({tag, " alu_b"},   64'(s.bb),   64'd0);
        check({tag, " busy"},    64'(s.busy), 64'd0);
        check({tag, " done"},    64'(s.done), 64'd0);
        check({tag, " result"},  64'(s.res),  64'd0);
        check({tag, " dbz"},     64'(s.dbz),  64'd0);
        check({tag, " timeout"}, 64'(s.to),   64'd0);
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic        saw_done;

        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        drive(1, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        check_zero(0, "reset0");
        check_zero(1, "reset1");
        repeat (3) @(negedge clk);
        rst_n0 = 1'b1;
        rst_n1 = 1'b1;

        // Directed cases
        run_txn(0, 3'b101, 32'd7,   32'd5,   "add");
        run_txn(0, 3'b111, 32'd17,  32'd5,   "mod17_5");
        run_txn(0, 3'b111, 32'd3,   32'd9,   "mod3_9");
        run_txn(0, 3'b111, 32'd42,  32'd0,   "divzero");
        run_txn(0, 3'b000, 32'hF0,  32'h3C,  "and_after_dbz");
        run_txn(1, 3'b111, 32'd100, 32'd1,   "timeout");
        run_txn(1, 3'b111, 32'd20,  32'd5,   "mod_at_limit");
        run_txn(1, 3'b111, 32'd21,  32'd5,   "mod_over_limit");
        run_txn(0, 3'b100, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        run_txn(0, 3'b110, 32'd0,   32'd1,   "sub_wrap");

        // Reset during SUB of 17 mod 5: aborts with no done
        @(negedge clk);
        drive(0, 1'b1, 3'b111, 32'd17, 32'd5);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 3'b000, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        check("midrst in SUB", 64'(bus0.alu_sel), 64'd6);
        rst_n0 = 1'b0;
        #1;
        check_zero(0, "midrst");
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus0.done) saw_done = 1'b1;
        end
        @(negedge clk);
        rst_n0 = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus0.done) saw_done = 1'b1;
        end
        check("midrst no done", 64'(saw_done), 64'd0);
        run_txn(0, 3'b010, 32'hFF, 32'h0F, "xor_after_rst");

        // Randomized transactions on both instances
        for (int i = 0; i < 60; i++) begin
            int inst;
            inst = i % 2;
            o = 3'($urandom);
            if (o != 3'b111) begin
                x = $urandom;
                y = $urandom;
            end else if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 32'h7FFF_FFFF);
                y = 32'h0;
            end else if (inst == 0) begin
                y = $urandom_range(1, 32'h0010_0000);
                x = $urandom_range(0, 40) * y + $urandom_range(0, y - 1);
            end else begin
                y = $urandom_range(1, 10);
                x = $urandom_range(0, 60);
            end
            run_txn(inst, o, x, y, (inst == 0) ? "rnd0" : "rnd1");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
